// File: rtl/matrix_pkg.sv
// Shared sizing constants and FSM encoding for the matrix streaming transmitter.
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;   // 200 bits
    localparam int DIM_W   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A dimension is usable when it is non-zero and does not exceed max_dim.
    function automatic logic dim_in_range(input logic [DIM_W-1:0] d, input int max_dim);
        return (d != '0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Row/column walker for a captured matrix: row-major order, with end-of-row
// and end-of-matrix flags derived from the captured dimensions.
module matrix_idx_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] m_cnt,
    input  logic [DIM_W-1:0] n_cnt,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last_col,
    output logic             last
);

    assign last_col = (col == n_cnt - DIM_W'(1));
    assign last     = last_col && (row == m_cnt - DIM_W'(1));

    // Step through elements; the index wraps to (0,0) after the final one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (last_col) begin
                row <= row + DIM_W'(1);
                col <= '0;
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_stream_tx.sv
// Accepts a packed matrix job and streams its elements row-major, one beat
// per out_valid/out_ready handshake, with row/column tags and end markers.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | ready for a job; bad dimensions produce a one-cycle err
//   ST_SEND | presenting captured elements until the last beat transfers
module matrix_stream_tx
    import matrix_pkg::*;
#(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int ELEM_W  = matrix_pkg::ELEM_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DIM_W-1:0]                  m_in,
    input  logic [DIM_W-1:0]                  n_in,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ELEM_W-1:0]                 out_data,
    output logic [DIM_W-1:0]                  out_row,
    output logic [DIM_W-1:0]                  out_col,
    output logic                              out_last_col,
    output logic                              out_last,
    output logic                              err,
    output logic                              busy
);

    localparam int NUM_EL = MAX_DIM * MAX_DIM;
    localparam int SEL_W  = $clog2(NUM_EL);

    state_t                       state_q;
    state_t                       state_d;
    logic [NUM_EL*ELEM_W-1:0]     mat_q;
    logic [DIM_W-1:0]             m_q;
    logic [DIM_W-1:0]             n_q;
    logic                         err_q;
    logic                         dims_ok;
    logic                         bad_req;
    logic                         load;
    logic                         xfer;
    logic [DIM_W-1:0]             row;
    logic [DIM_W-1:0]             col;
    logic                         last_col;
    logic                         last;
    logic [SEL_W-1:0]             sel;
    logic [ELEM_W-1:0]            elems [NUM_EL];

    assign dims_ok = dim_in_range(m_in, MAX_DIM) && dim_in_range(n_in, MAX_DIM);
    assign bad_req = (state_q == ST_IDLE) && in_valid && !dims_ok;

    // Unpacked view of the captured matrix for simple element selection.
    for (genvar g = 0; g < NUM_EL; g++) begin : g_elem
        assign elems[g] = mat_q[g*ELEM_W +: ELEM_W];
    end

    assign sel = SEL_W'(row) * SEL_W'(MAX_DIM) + SEL_W'(col);

    matrix_idx_counter u_idx (
        .clk      (clk),
        .reset    (reset),
        .clear    (load),
        .advance  (xfer),
        .m_cnt    (m_q),
        .n_cnt    (n_q),
        .row      (row),
        .col      (col),
        .last_col (last_col),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && dims_ok) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    xfer = 1'b1;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Job capture; held untouched while streaming so input changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mat_q <= '0;
            m_q   <= '0;
            n_q   <= '0;
        end else if (load) begin
            mat_q <= matrix_in;
            m_q   <= m_in;
            n_q   <= n_in;
        end
    end

    // One-cycle error pulse for a rejected job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bad_req;
        end
    end

    assign err = err_q;

    // Beat fields are forced to zero outside SEND so idle/reset outputs are clean.
    always_comb begin
        out_data     = '0;
        out_row      = '0;
        out_col      = '0;
        out_last_col = 1'b0;
        out_last     = 1'b0;
        if (out_valid) begin
            out_data     = elems[sel];
            out_row      = row;
            out_col      = col;
            out_last_col = last_col;
            out_last     = last;
        end
    end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: inputs change and outputs are sampled
// on the falling clock edge.
module tb_matrix_stream_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   m_in;
    logic [2:0]   n_in;
    logic [199:0] matrix_in;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_last_col;
    logic         out_last;
    logic         err;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_stream_tx dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .m_in         (m_in),
        .n_in         (n_in),
        .matrix_in    (matrix_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last_col (out_last_col),
        .out_last     (out_last),
        .err          (err),
        .busy         (busy)
    );

    function automatic logic [199:0] put(input logic [199:0] mat, input int r, input int c,
                                         input logic [7:0] v);
        logic [199:0] m;
        m = mat;
        m[(r*5+c)*8 +: 8] = v;
        return m;
    endfunction

    // Offer one job for a single cycle; returns on the falling edge where the
    // first beat (if accepted) is visible.
    task automatic offer(input logic [2:0] m, input logic [2:0] n, input logic [199:0] mat);
        @(negedge clk);
        in_valid  = 1'b1;
        m_in      = m;
        n_in      = n;
        matrix_in = mat;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({in_ready, out_valid, busy, err, out_last_col, out_last} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/vld/busy/err/lc/l=%b expected 100000",
                     {in_ready, out_valid, busy, err, out_last_col, out_last});
        end
        total++;
        if ({out_data, out_row, out_col} !== 14'd0) begin
            bad++;
            $display("FAIL reset_fields: got data=%0d row=%0d col=%0d expected all 0",
                     out_data, out_row, out_col);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_row_1x3();
        logic [199:0] mat;
        mat = '0;
        mat = put(mat, 0, 0, 8'd1);
        mat = put(mat, 0, 1, 8'd2);
        mat = put(mat, 0, 2, 8'd3);
        out_ready = 1'b1;
        offer(3'd1, 3'd3, mat);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || out_row !== 3'd0 ||
                out_col !== 3'(i) || out_last_col !== (i == 2) || out_last !== (i == 2)) begin
                bad++;
                $display("FAIL row_1x3 beat %0d: got vld=%b data=%0d row=%0d col=%0d lc=%b l=%b expected 1 %0d 0 %0d %b %b",
                         i, out_valid, out_data, out_row, out_col, out_last_col, out_last,
                         i + 1, i, i == 2, i == 2);
            end
            @(negedge clk);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL row_1x3_done: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_full_5x5();
        logic [199:0] mat;
        int r;
        int c;
        mat = '0;
        for (int k = 0; k < 25; k++) mat = put(mat, k / 5, k % 5, 8'(k + 1));
        out_ready = 1'b1;
        offer(3'd5, 3'd5, mat);
        for (int k = 0; k < 25; k++) begin
            r = k / 5;
            c = k % 5;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(k + 1) || out_row !== 3'(r) ||
                out_col !== 3'(c) || out_last_col !== (c == 4) || out_last !== (k == 24) ||
                busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_5x5 beat %0d: got vld=%b data=%0d row=%0d col=%0d lc=%b l=%b expected 1 %0d %0d %0d %b %b",
                         k, out_valid, out_data, out_row, out_col, out_last_col, out_last,
                         k + 1, r, c, c == 4, k == 24);
            end
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_5x5_done: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [199:0] mat;
        mat = '0;
        mat = put(mat, 0, 0, 8'd10);
        mat = put(mat, 0, 1, 8'd20);
        mat = put(mat, 1, 0, 8'd30);
        mat = put(mat, 1, 1, 8'd40);
        out_ready = 1'b1;
        offer(3'd2, 3'd2, mat);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd10) begin
            bad++;
            $display("FAIL bp_beat0: got vld=%b data=%0d expected 1 10", out_valid, out_data);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd20) begin
            bad++;
            $display("FAIL bp_beat1: got vld=%b data=%0d expected 1 20", out_valid, out_data);
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'd20 || out_row !== 3'd0 ||
                out_col !== 3'd1 || out_last_col !== 1'b1 || out_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold %0d: got vld=%b data=%0d row=%0d col=%0d lc=%b l=%b expected 1 20 0 1 1 0",
                         s, out_valid, out_data, out_row, out_col, out_last_col, out_last);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd30 || out_row !== 3'd1 || out_col !== 3'd0) begin
            bad++;
            $display("FAIL bp_beat2: got vld=%b data=%0d row=%0d col=%0d expected 1 30 1 0",
                     out_valid, out_data, out_row, out_col);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd40 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL bp_beat3: got vld=%b data=%0d last=%b expected 1 40 1",
                     out_valid, out_data, out_last);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_done: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bad_dims();
        logic [2:0] m;
        logic [2:0] n;
        for (int t = 0; t < 2; t++) begin
            m = (t == 0) ? 3'd0 : 3'd6;
            n = (t == 0) ? 3'd3 : 3'd2;
            @(negedge clk);
            in_valid  = 1'b1;
            m_in      = m;
            n_in      = n;
            matrix_in = {200{1'b1}};
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_dims %0d pulse: got err=%b vld=%b rdy=%b busy=%b expected 1 0 1 0",
                         t, err, out_valid, in_ready, busy);
            end
            @(negedge clk);
            total++;
            if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL bad_dims %0d after: got err=%b vld=%b rdy=%b expected 0 0 1",
                         t, err, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_capture_hold();
        logic [199:0] mat;
        int r;
        int c;
        mat = '0;
        for (int k = 0; k < 6; k++) mat = put(mat, k / 3, k % 3, 8'((k / 3) * 16 + (k % 3) + 1));
        out_ready = 1'b1;
        offer(3'd2, 3'd3, mat);
        matrix_in = {200{1'b1}};
        m_in      = 3'd7;
        n_in      = 3'd0;
        in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            r = k / 3;
            c = k % 3;
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(r * 16 + c + 1) || out_row !== 3'(r) ||
                out_col !== 3'(c) || out_last !== (k == 5) || err !== 1'b0) begin
                bad++;
                $display("FAIL capture beat %0d: got vld=%b data=%0d row=%0d col=%0d l=%b err=%b expected 1 %0d %0d %0d %b 0",
                         k, out_valid, out_data, out_row, out_col, out_last, err,
                         r * 16 + c + 1, r, c, k == 5);
            end
            if (k == 5) in_valid = 1'b0;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL capture_done: got vld=%b rdy=%b err=%b expected 0 1 0",
                     out_valid, in_ready, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [199:0] mat;
        mat = '0;
        for (int k = 0; k < 25; k++) mat = put(mat, k / 5, k % 5, 8'(k + 1));
        out_ready = 1'b1;
        offer(3'd5, 3'd5, mat);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(k + 1)) begin
                bad++;
                $display("FAIL rst_mid beat %0d: got vld=%b data=%0d expected 1 %0d",
                         k, out_valid, out_data, k + 1);
            end
            @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 8'd0 ||
            out_row !== 3'd0 || out_col !== 3'd0) begin
            bad++;
            $display("FAIL rst_mid_async: got vld=%b rdy=%b busy=%b data=%0d row=%0d col=%0d expected 0 1 0 0 0 0",
                     out_valid, in_ready, busy, out_data, out_row, out_col);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_discard %0d: got vld=%b rdy=%b expected 0 1",
                         s, out_valid, in_ready);
            end
        end
        mat = put('0, 0, 0, 8'd7);
        offer(3'd1, 3'd1, mat);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd7 || out_last_col !== 1'b1 ||
            out_last !== 1'b1 || out_row !== 3'd0 || out_col !== 3'd0) begin
            bad++;
            $display("FAIL one_by_one: got vld=%b data=%0d lc=%b l=%b row=%0d col=%0d expected 1 7 1 1 0 0",
                     out_valid, out_data, out_last_col, out_last, out_row, out_col);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL one_by_one_done: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m_in      = 3'd0;
        n_in      = 3'd0;
        matrix_in = '0;
        test_reset();
        test_row_1x3();
        test_full_5x5();
        test_backpressure();
        test_bad_dims();
        test_capture_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
